rst_req_gen: RTL and testbench



---
 rtl/rst_req_pkg.sv | 22 ++
 rtl/rst_req_wdt.sv | 44 ++++
 rtl/rst_req_gen.sv | 131 +++++++++++++
 tb/tb_rst_req_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rst_req_pkg.sv
// Shared types and default sizing for the system reset request generator.
package rst_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_SW  = 2'd0,
    CAUSE_DBG = 2'd1,
    CAUSE_EXT = 2'd2,
    CAUSE_WDT = 2'd3
  } cause_e;

  localparam int unsigned DEF_PULSE_CYCLES   = 16;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 64;
  localparam int unsigned DEF_CNT_W          = 8;
  localparam int unsigned DEF_WDT_CYCLES     = 32'd1 << 20;

endpackage

// File: rtl/rst_req_wdt.sv
// Idle watchdog for rst_req_gen; only built when RST_REQ_GEN_WDT_EN is defined.
// Down-counts while idle and unkicked; zero_o flags expiry until the next reload.
`ifdef RST_REQ_GEN_WDT_EN
module rst_req_wdt
  import rst_req_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = DEF_WDT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick_i,
  input  logic idle_i,
  output logic zero_o
);

  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (kick_i || !idle_i) begin
      cnt_d = WDT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WDT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= WDT_LOAD;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule
`endif

// File: rtl/rst_req_gen.sv
// System reset request generator: fixed-width srst_req_n pulse, hold-off, cause/count log.
// Optional idle watchdog request source enabled by RST_REQ_GEN_WDT_EN.
module rst_req_gen
  import rst_req_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
`ifdef RST_REQ_GEN_WDT_EN
  ,
  parameter int unsigned WDT_CYCLES     = DEF_WDT_CYCLES
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req_valid,
  input  logic [1:0]       req_cause,
`ifdef RST_REQ_GEN_WDT_EN
  input  logic             wdt_kick,
`endif
  output logic             req_ready,
  output logic             srst_req_n,
  output logic             busy,
  output logic [1:0]       last_cause,
  output logic [CNT_W-1:0] rst_count
);

  localparam int unsigned MAX_CYC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CTR_W   = $clog2(MAX_CYC + 1);
  localparam logic [CTR_W-1:0] PULSE_LOAD = CTR_W'(PULSE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LOAD  = CTR_W'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             srst_n_q, srst_n_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             idle_c;
  logic             req_v_c;
  logic [1:0]       req_cause_c;

  assign idle_c = (state_q == IDLE);

  // Request source: external port, plus the watchdog when built (external wins).
`ifdef RST_REQ_GEN_WDT_EN
  logic wdt_zero;

  rst_req_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .kick_i (wdt_kick),
    .idle_i (idle_c),
    .zero_o (wdt_zero)
  );

  assign req_v_c     = req_valid | (wdt_zero & idle_c);
  assign req_cause_c = req_valid ? req_cause : CAUSE_WDT;
`else
  assign req_v_c     = req_valid;
  assign req_cause_c = req_cause;
`endif

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    srst_n_d = 1'b1;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_v_c) begin
          state_d  = ASSERT;
          ctr_d    = PULSE_LOAD;
          cause_d  = req_cause_c;
          srst_n_d = 1'b0;
        end
      end
      ASSERT: begin
        srst_n_d = 1'b0;
        if (ctr_q == '0) begin
          srst_n_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            ctr_d   = HOLD_LOAD;
          end
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      HOLDOFF: begin
        if (ctr_q == '0) begin
          state_d = IDLE;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      srst_n_q <= 1'b1;
      cause_q  <= CAUSE_SW;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      srst_n_q <= srst_n_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready  = idle_c;
  assign busy       = !idle_c;
  assign srst_req_n = srst_n_q;
  assign last_cause = cause_q;
  assign rst_count  = cnt_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// Directed bench for rst_req_gen: default sizing instance plus a 1-cycle pulse,
// zero hold-off, 2-bit counter instance.
module tb_rst_req_gen;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       v0, v1;
  logic [1:0] c0, c1;

  logic       rdy0, srst0, busy0;
  logic [1:0] lc0;
  logic [7:0] cnt0;
  logic       rdy1, srst1, busy1;
  logic [1:0] lc1;
  logic [1:0] cnt1;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  rst_req_gen u0 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (v0),
    .req_cause  (c0),
    .req_ready  (rdy0),
    .srst_req_n (srst0),
    .busy       (busy0),
    .last_cause (lc0),
    .rst_count  (cnt0)
  );

  rst_req_gen #(.PULSE_CYCLES(1), .HOLDOFF_CYCLES(0), .CNT_W(2)) u1 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (v1),
    .req_cause  (c1),
    .req_ready  (rdy1),
    .srst_req_n (srst1),
    .busy       (busy1),
    .last_cause (lc1),
    .rst_count  (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  initial begin
    int  k;
    int  first_low;
    int  second_low;
    logic prev;

    sys_rst_n = 1'b0;
    v0 = 1'b0; c0 = 2'd0;
    v1 = 1'b0; c1 = 2'd0;
    nclk(3);
    sys_rst_n = 1'b1;

    // Reset exit values
    chk("rst_srst0", srst0, 1);
    chk("rst_rdy0",  rdy0,  1);
    chk("rst_busy0", busy0, 0);
    chk("rst_cnt0",  cnt0,  0);
    chk("rst_lc0",   lc0,   0);
    chk("rst_srst1", srst1, 1);
    chk("rst_rdy1",  rdy1,  1);

    // One-cycle request, cause DBG: 16 low cycles, 64 hold-off cycles, then ready
    v0 = 1'b1; c0 = 2'd1;
    nclk(1);
    v0 = 1'b0; c0 = 2'd0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pulse_low_%0d", i), srst0, 0);
      chk($sformatf("pulse_busy_%0d", i), busy0, 1);
      nclk(1);
    end
    chk("pulse_end_high", srst0, 1);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("hold_rdy_%0d", i), rdy0, 0);
      chk($sformatf("hold_srst_%0d", i), srst0, 1);
      nclk(1);
    end
    chk("after_hold_rdy",  rdy0,  1);
    chk("after_hold_busy", busy0, 0);
    chk("after_hold_cnt",  cnt0,  1);
    chk("after_hold_lc",   lc0,   1);

    // Held request, cause EXT: second pulse starts 16 + 64 + 1 cycles after the
    // first (the extra cycle is the IDLE cycle in which it is accepted)
    v0 = 1'b1; c0 = 2'd2;
    first_low = -1; second_low = -1;
    prev = 1'b1;
    k = 0;
    while (second_low < 0 && k < 200) begin
      nclk(1);
      k++;
      if (prev && !srst0) begin
        if (first_low < 0) first_low = k;
        else second_low = k;
      end
      prev = srst0;
    end
    v0 = 1'b0; c0 = 2'd0;
    chk("held_first_start", first_low, 1);
    chk("held_spacing", second_low - first_low, 81);
    chk("held_lc", lc0, 2);
    nclk(20);
    chk("held_cnt", cnt0, 3);

    // Minimal pulse, no hold-off, cause WDT code from the port
    v1 = 1'b1; c1 = 2'd3;
    nclk(1);
    v1 = 1'b0; c1 = 2'd0;
    chk("min_low",  srst1, 0);
    chk("min_busy", busy1, 1);
    chk("min_rdy",  rdy1,  0);
    chk("min_lc",   lc1,   3);
    nclk(1);
    chk("min_high", srst1, 1);
    chk("min_rdy_after", rdy1, 1);
    chk("min_cnt", cnt1, 1);

    // Back-to-back requests on the 2-bit counter: saturates at 3
    v1 = 1'b1; c1 = 2'd0;
    for (int i = 0; i < 6; i++) begin
      nclk(1);
      chk($sformatf("sat_low_%0d", i), srst1, 0);
      nclk(1);
      chk($sformatf("sat_cnt_%0d", i), cnt1, (i + 2 > 3) ? 3 : i + 2);
      if (i == 5) v1 = 1'b0;
    end
    nclk(2);
    chk("sat_final_cnt", cnt1, 3);
    chk("sat_final_lc",  lc1,  0);
    chk("sat_final_srst", srst1, 1);

    // Asynchronous reset during the 5th low cycle of a pulse
    nclk(80);
    chk("pre_mid_rdy", rdy0, 1);
    v0 = 1'b1; c0 = 2'd1;
    nclk(1);
    v0 = 1'b0; c0 = 2'd0;
    nclk(4);
    chk("mid_low_c5", srst0, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_async_srst", srst0, 1);
    chk("mid_async_busy", busy0, 0);
    chk("mid_async_cnt",  cnt0,  0);
    nclk(2);
    sys_rst_n = 1'b1;
    chk("mid_rel_rdy", rdy0, 1);
    chk("mid_rel_lc",  lc0,  0);
    nclk(5);
    chk("mid_idle_srst", srst0, 1);
    chk("mid_idle_cnt",  cnt0,  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
